// File: rtl/tf32_addsub_pipe_if.sv
// Operand/result handshake bundle for the TF32 add/sub pipeline.
// master = upstream/downstream environment, slave = the pipeline itself.
interface tf32_addsub_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [18:0] operand_A;
  logic [18:0] operand_B;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [18:0] result;

  modport master (
    output in_valid, operand_A, operand_B, in_sub, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, operand_A, operand_B, in_sub, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/tf32_addsub_pipe.sv
// 3-stage TF32 adder/subtractor (align, add, normalize/round/pack), RNE,
// flush-to-zero on underflow and saturate-to-max-finite on overflow.
module tf32_addsub_pipe (
  input  logic                     clk,
  input  logic                     rst_n,
  tf32_addsub_pipe_if.slave        bus
);
  logic        adv;

  logic        s1_valid_q, s1_valid_d, s1_sign_q, s1_sign_d;
  logic        s1_eff_sub_q, s1_eff_sub_d, s1_neg_zero_q, s1_neg_zero_d;
  logic [7:0]  s1_exp_q, s1_exp_d;
  logic [13:0] s1_mx_q, s1_mx_d, s1_my_q, s1_my_d;

  logic        s2_valid_q, s2_valid_d, s2_sign_q, s2_sign_d;
  logic        s2_neg_zero_q, s2_neg_zero_d;
  logic [7:0]  s2_exp_q, s2_exp_d;
  logic [14:0] s2_sum_q, s2_sum_d;

  logic        out_valid_q, out_valid_d;
  logic [18:0] result_q, result_d;

  logic        sign_b_eff, swap, sign_x, sign_y;
  logic [17:0] mag_x, mag_y;
  logic [7:0]  d;
  logic [13:0] ext_y, y_al;
  logic [27:0] wide_y;

  logic        carry, rnd_up, ovf;
  logic [3:0]  lzc;
  logic [13:0] norm;
  logic [11:0] mant_r;
  logic [9:0]  frac, exp_n;
  logic [18:0] packed_res;

  assign adv           = ~out_valid_q | bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;

  // Stage 1: order by magnitude, align the smaller operand with G/R/sticky.
  always_comb begin
    sign_b_eff = bus.operand_B[18] ^ bus.in_sub;
    swap       = bus.operand_B[17:0] > bus.operand_A[17:0];
    mag_x      = swap ? bus.operand_B[17:0] : bus.operand_A[17:0];
    mag_y      = swap ? bus.operand_A[17:0] : bus.operand_B[17:0];
    sign_x     = swap ? sign_b_eff : bus.operand_A[18];
    sign_y     = swap ? bus.operand_A[18] : sign_b_eff;
    d          = mag_x[17:10] - mag_y[17:10];
    ext_y      = {|mag_y[17:10], mag_y[9:0], 3'b000};
    wide_y     = {ext_y, 14'h0} >> d;
    y_al       = (d >= 8'd13) ? {13'h0, |ext_y}
                              : {wide_y[27:15], wide_y[14] | (|wide_y[13:0])};

    s1_valid_d    = s1_valid_q;
    s1_sign_d     = s1_sign_q;
    s1_eff_sub_d  = s1_eff_sub_q;
    s1_neg_zero_d = s1_neg_zero_q;
    s1_exp_d      = s1_exp_q;
    s1_mx_d       = s1_mx_q;
    s1_my_d       = s1_my_q;
    if (adv) begin
      s1_valid_d    = bus.in_valid;
      s1_sign_d     = sign_x;
      s1_eff_sub_d  = sign_x ^ sign_y;
      s1_neg_zero_d = (bus.operand_A[17:10] == 8'h0) && (bus.operand_B[17:10] == 8'h0)
                      && bus.operand_A[18] && sign_b_eff;
      s1_exp_d      = mag_x[17:10];
      s1_mx_d       = {|mag_x[17:10], mag_x[9:0], 3'b000};
      s1_my_d       = y_al;
    end
  end

  // Stage 2: magnitude add/subtract; X >= Y so the difference is never negative.
  always_comb begin
    s2_valid_d    = s2_valid_q;
    s2_sign_d     = s2_sign_q;
    s2_neg_zero_d = s2_neg_zero_q;
    s2_exp_d      = s2_exp_q;
    s2_sum_d      = s2_sum_q;
    if (adv) begin
      s2_valid_d    = s1_valid_q;
      s2_sign_d     = s1_sign_q;
      s2_neg_zero_d = s1_neg_zero_q;
      s2_exp_d      = s1_exp_q;
      s2_sum_d      = s1_eff_sub_q ? ({1'b0, s1_mx_q} - {1'b0, s1_my_q})
                                   : ({1'b0, s1_mx_q} + {1'b0, s1_my_q});
    end
  end

  // Stage 3: normalize, round to nearest even, then apply zero/range rules.
  always_comb begin
    carry = s2_sum_q[14];
    lzc   = '0;
    if (!carry) begin
      for (int unsigned i = 0; i < 14; i++) begin
        if (s2_sum_q[i]) lzc = 4'(13 - i);
      end
    end
    norm   = carry ? {s2_sum_q[14:2], s2_sum_q[1] | s2_sum_q[0]} : (s2_sum_q[13:0] << lzc);
    rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r = {1'b0, norm[13:3]} + {11'h0, rnd_up};
    ovf    = mant_r[11];
    frac   = ovf ? mant_r[10:1] : mant_r[9:0];
    exp_n  = {2'b00, s2_exp_q} + {9'h0, carry} + {9'h0, ovf} - {6'h0, lzc};

    if (s2_sum_q == '0)
      packed_res = s2_neg_zero_q ? 19'h40000 : '0;
    else if (exp_n[9] || (exp_n == '0))
      packed_res = '0;
    else if (exp_n >= 10'd255)
      packed_res = {s2_sign_q, 8'hFE, 10'h3FF};
    else
      packed_res = {s2_sign_q, exp_n[7:0], frac};

    out_valid_d = adv ? s2_valid_q : out_valid_q;
    result_d    = adv ? packed_res : result_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_sign_q     <= 1'b0;
      s1_eff_sub_q  <= 1'b0;
      s1_neg_zero_q <= 1'b0;
      s1_exp_q      <= '0;
      s1_mx_q       <= '0;
      s1_my_q       <= '0;
      s2_valid_q    <= 1'b0;
      s2_sign_q     <= 1'b0;
      s2_neg_zero_q <= 1'b0;
      s2_exp_q      <= '0;
      s2_sum_q      <= '0;
      out_valid_q   <= 1'b0;
      result_q      <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_sign_q     <= s1_sign_d;
      s1_eff_sub_q  <= s1_eff_sub_d;
      s1_neg_zero_q <= s1_neg_zero_d;
      s1_exp_q      <= s1_exp_d;
      s1_mx_q       <= s1_mx_d;
      s1_my_q       <= s1_my_d;
      s2_valid_q    <= s2_valid_d;
      s2_sign_q     <= s2_sign_d;
      s2_neg_zero_q <= s2_neg_zero_d;
      s2_exp_q      <= s2_exp_d;
      s2_sum_q      <= s2_sum_d;
      out_valid_q   <= out_valid_d;
      result_q      <= result_d;
    end
  end
endmodule
